// File: rtl/imm_extend_stage.sv
// imm_extend_stage: 2-entry FIFO that decodes and stores the extended immediate of each instruction at push
// Ports: clk/reset (sync, active-high), flush drops all entries,
//        in_valid/in_ready/in_instr/in_pc upstream handshake,
//        out_valid/out_ready/out_instr/out_pc/out_imm/out_kind head entry.
// Optional feature: define IMM_MOVZ_EN to decode MOVZ as kind 5.
module imm_extend_stage #(
    parameter int BR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic [63:0] out_imm,
    output logic [2:0]  out_kind
);
    logic [31:0] instr_q [2];
    logic [63:0] pc_q [2];
    logic [63:0] imm_q [2];
    logic [2:0]  kind_q [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        push, pop;
    logic        is_i, is_d, is_b, is_cb, is_mz;
    logic [63:0] mz_imm, imm_d;
    logic [2:0]  kind_d;

    always_comb begin
        is_i  = in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1101000100;
        is_d  = in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000;
        is_b  = in_instr[31:26] == 6'b000101;
        is_cb = in_instr[31:24] == 8'b10110100 || in_instr[31:24] == 8'b01010100;
`ifdef IMM_MOVZ_EN
        is_mz  = in_instr[31:23] == 9'b110100101;
        mz_imm = {48'b0, in_instr[20:5]} << {in_instr[22:21], 4'b0};
`else
        is_mz  = 1'b0;
        mz_imm = '0;
`endif
        kind_d = is_i ? 3'd1 : is_d ? 3'd2 : is_b ? 3'd3 : is_cb ? 3'd4 : is_mz ? 3'd5 : 3'd0;
        imm_d  = is_i  ? {52'b0, in_instr[21:10]} :
                 is_d  ? {{55{in_instr[20]}}, in_instr[20:12]} :
                 is_b  ? {{38{in_instr[25]}}, in_instr[25:0]} << BR_SHIFT :
                 is_cb ? {{45{in_instr[23]}}, in_instr[23:5]} << BR_SHIFT :
                 is_mz ? mz_imm : '0;
        in_ready  = count < 2'd2;
        out_valid = count != 2'd0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_instr = out_valid ? instr_q[rd_ptr] : '0;
        out_pc    = out_valid ? pc_q[rd_ptr] : '0;
        out_imm   = out_valid ? imm_q[rd_ptr] : '0;
        out_kind  = out_valid ? kind_q[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= in_instr;
                pc_q[wr_ptr]    <= in_pc;
                imm_q[wr_ptr]   <= imm_d;
                kind_q[wr_ptr]  <= kind_d;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 SHALL have parameter BR_SHIFT, default 2: left-shift amount applied to branch offsets (B, CB).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port flush, input, 1: discard all buffered instructions.
REQ-005 SHALL have port in_valid, input, 1: upstream offers instruction.
REQ-006 SHALL have port in_ready, output, 1: stage accepts instruction this cycle.
REQ-007 SHALL have port in_instr, input, 32: fetched instruction word.
REQ-008 SHALL have port in_pc, input, 64: PC of in_instr.
REQ-009 SHALL have port out_valid, output, 1: head entry valid.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes head.
REQ-011 SHALL have port out_instr, output, 32: head instruction.
REQ-012 SHALL have port out_pc, output, 64: head PC.
REQ-013 SHALL have port out_imm, output, 64: extended immediate of head.
REQ-014 SHALL have port out_kind, output, 3: immediate class of head (0 none, 1 I, 2 D, 3 B, 4 CB, 5 MOVZ).

Function
REQ-015 SHALL buffer up to 2 entries (instr, pc, imm, kind) in FIFO order; count range 0..2.
REQ-016 SHALL drive in_ready = (count < 2), registered-state only, no combinational path from out_ready.
REQ-017 SHALL push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-018 SHALL keep count unchanged on simultaneous push and pop (count 1 only); head advances, new entry becomes head.
REQ-019 SHALL assert out_valid = (count > 0); out_* reflect head entry; latency in-to-out = 1 cycle when empty.
REQ-020 SHALL hold out_* stable while out_valid && !out_ready.
REQ-021 SHALL compute imm/kind at push from in_instr and store it; no recomputation at pop.
REQ-022 I-type (bits31:22 = 1001000100 or 1101000100): kind 1, imm = zero-extend bits21:10 to 64.
REQ-023 D-type (bits31:21 = 11111000010 or 11111000000): kind 2, imm = sign-extend bits20:12 to 64.
REQ-024 B (bits31:26 = 000101): kind 3, imm = sign-extend(bits25:0) << BR_SHIFT, truncated to 64.
REQ-025 CB (bits31:24 = 10110100 or 01010100): kind 4, imm = sign-extend(bits23:5) << BR_SHIFT.
REQ-026 Any other encoding: kind 0, imm = 0.
REQ-027 flush SHALL set count to 0 next cycle; a push in the same cycle as flush is discarded; pop in same cycle is irrelevant.
REQ-028 Pointers SHALL wrap modulo 2; no overflow possible since push requires in_ready.

Reset
REQ-029 reset SHALL override flush and handshakes; next cycle count = 0, pointers = 0.
REQ-030 After reset: out_valid 0, in_ready 1, out_instr 0, out_pc 0, out_imm 0, out_kind 0.
REQ-031 Reset asserted mid-transfer SHALL drop all entries; no partial entry survives.

Configuration
REQ-032 Macro IMM_MOVZ_EN: when defined, MOVZ (bits31:23 = 110100101) SHALL give kind 5, imm = zero-extend(bits20:5) << (16 * bits22:21).
REQ-033 Without IMM_MOVZ_EN, MOVZ encodings SHALL be kind 0, imm 0; port list unchanged.

Verification
REQ-034 Reset, then push ADDI instr 0x91000C20 (imm12 = 3) with out_ready=1 -> next cycle out_valid 1, out_kind 1, out_imm 0x3.
REQ-035 Push LDUR with imm9 = 0x1F8 (-8) -> out_kind 2, out_imm 0xFFFFFFFFFFFFFFF8.
REQ-036 Push B with imm26 = 0x3FFFFFF, BR_SHIFT=2 -> out_kind 3, out_imm 0xFFFFFFFFFFFFFFFC; CBZ imm19 = 0x10 -> out_imm 0x40.
REQ-037 out_ready=0, push 3 instrs back-to-back -> third blocked (in_ready 0 after 2 pushes); release out_ready -> outputs in order A, B, C, none lost or duplicated.
REQ-038 count=2, assert flush with in_valid=1 -> next cycle out_valid 0, in_ready 1, pushed instr absent.
REQ-039 MOVZ hw=2 imm16=0x1234: with IMM_MOVZ_EN -> kind 5, imm 0x0000123400000000; without -> kind 0, imm 0.
